// File: rtl/fifo_btn_ctrl.sv
// fifo_btn_ctrl: push/pop button front end for the 8-bit FIFO.
// Each raw button is synchronised, debounced by a small FSM and turned into
// one registered strobe per debounced press. The strobe is gated against the
// FIFO occupancy, and a rejected request becomes an error pulse instead.
module fifo_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20,
    parameter int DEPTH           = 16,
    parameter int COUNT_W         = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    input  logic               btn_out,
    input  logic [7:0]         sw_data,
    input  logic [COUNT_W-1:0] count,
    output logic               en_in,
    output logic               en_out,
    output logic [7:0]         din,
    output logic               ovf_err,
    output logic               udf_err
);

    // Debounce FSM encoding, shared by both channels
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESS   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_HELD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] EMPTY_C  = '0;

    // Synchroniser flops for the two raw buttons
    logic r_inSync1;
    logic r_inSync2;
    logic r_outSync1;
    logic r_outSync2;

    // Push channel debounce state
    logic [2:0]       r_inState;
    logic [CNT_W-1:0] r_inCnt;
    logic [2:0]       w_inStateNext;
    logic [CNT_W-1:0] w_inCntNext;

    // Pop channel debounce state
    logic [2:0]       r_outState;
    logic [CNT_W-1:0] r_outCnt;
    logic [2:0]       w_outStateNext;
    logic [CNT_W-1:0] w_outCntNext;

    // Registered outputs
    logic       r_enIn;
    logic       r_enOut;
    logic [7:0] r_din;
    logic       r_ovfErr;
    logic       r_udfErr;

    // FIFO occupancy gates, both evaluated on the same count value
    logic w_inRoom;
    logic w_outAvail;

    assign w_inRoom   = (count < DEPTH_C);
    assign w_outAvail = (count != EMPTY_C);

    assign en_in   = r_enIn;
    assign en_out  = r_enOut;
    assign din     = r_din;
    assign ovf_err = r_ovfErr;
    assign udf_err = r_udfErr;

    // Two-flop synchronisers bring the asynchronous buttons into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inSync1  <= 1'b0;
            r_inSync2  <= 1'b0;
            r_outSync1 <= 1'b0;
            r_outSync2 <= 1'b0;
        end else begin
            r_inSync1  <= btn_in;
            r_inSync2  <= r_inSync1;
            r_outSync1 <= btn_out;
            r_outSync2 <= r_outSync1;
        end
    end

    // Push channel next state: a level must hold DEBOUNCE_CYCLES cycles to count
    always_comb begin
        w_inStateNext = r_inState;
        w_inCntNext   = r_inCnt;
        case (r_inState)
            S_IDLE: begin
                if (r_inSync2) begin
                    w_inStateNext = S_PRESS;
                    w_inCntNext   = CNT_ZERO;
                end
            end
            S_PRESS: begin
                if (!r_inSync2) begin
                    w_inStateNext = S_IDLE;
                end else if (r_inCnt == CNT_LAST) begin
                    w_inStateNext = S_FIRE;
                end else begin
                    w_inCntNext = r_inCnt + CNT_ONE;
                end
            end
            S_FIRE: begin
                w_inStateNext = S_HELD;
            end
            S_HELD: begin
                if (!r_inSync2) begin
                    w_inStateNext = S_RELEASE;
                    w_inCntNext   = CNT_ZERO;
                end
            end
            S_RELEASE: begin
                if (r_inSync2) begin
                    w_inStateNext = S_HELD;
                end else if (r_inCnt == CNT_LAST) begin
                    w_inStateNext = S_IDLE;
                end else begin
                    w_inCntNext = r_inCnt + CNT_ONE;
                end
            end
            default: begin
                w_inStateNext = S_IDLE;
                w_inCntNext   = CNT_ZERO;
            end
        endcase
    end

    // Pop channel next state, identical to the push channel but independent
    always_comb begin
        w_outStateNext = r_outState;
        w_outCntNext   = r_outCnt;
        case (r_outState)
            S_IDLE: begin
                if (r_outSync2) begin
                    w_outStateNext = S_PRESS;
                    w_outCntNext   = CNT_ZERO;
                end
            end
            S_PRESS: begin
                if (!r_outSync2) begin
                    w_outStateNext = S_IDLE;
                end else if (r_outCnt == CNT_LAST) begin
                    w_outStateNext = S_FIRE;
                end else begin
                    w_outCntNext = r_outCnt + CNT_ONE;
                end
            end
            S_FIRE: begin
                w_outStateNext = S_HELD;
            end
            S_HELD: begin
                if (!r_outSync2) begin
                    w_outStateNext = S_RELEASE;
                    w_outCntNext   = CNT_ZERO;
                end
            end
            S_RELEASE: begin
                if (r_outSync2) begin
                    w_outStateNext = S_HELD;
                end else if (r_outCnt == CNT_LAST) begin
                    w_outStateNext = S_IDLE;
                end else begin
                    w_outCntNext = r_outCnt + CNT_ONE;
                end
            end
            default: begin
                w_outStateNext = S_IDLE;
                w_outCntNext   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers for both debounce FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inState  <= S_IDLE;
            r_inCnt    <= CNT_ZERO;
            r_outState <= S_IDLE;
            r_outCnt   <= CNT_ZERO;
        end else begin
            r_inState  <= w_inStateNext;
            r_inCnt    <= w_inCntNext;
            r_outState <= w_outStateNext;
            r_outCnt   <= w_outCntNext;
        end
    end

    // Push strobe or overflow pulse, one cycle after the FSM enters FIRE; din holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enIn   <= 1'b0;
            r_ovfErr <= 1'b0;
            r_din    <= 8'd0;
        end else begin
            r_enIn   <= 1'b0;
            r_ovfErr <= 1'b0;
            if (r_inState == S_FIRE) begin
                if (w_inRoom) begin
                    r_enIn <= 1'b1;
                    r_din  <= sw_data;
                end else begin
                    r_ovfErr <= 1'b1;
                end
            end
        end
    end

    // Pop strobe or underflow pulse, one cycle after the FSM enters FIRE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enOut  <= 1'b0;
            r_udfErr <= 1'b0;
        end else begin
            r_enOut  <= 1'b0;
            r_udfErr <= 1'b0;
            if (r_outState == S_FIRE) begin
                if (w_outAvail) begin
                    r_enOut <= 1'b1;
                end else begin
                    r_udfErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// tb_fifo_btn_ctrl: directed bench for the FIFO button front end
// with DEBOUNCE_CYCLES=4 and DEPTH=16. Expected latencies and values are
// hand-derived: a button driven high just after posedge number c gives its
// strobe in the cycle after posedge number c+8.
module tb_fifo_btn_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_out;
    logic [7:0] sw_data;
    logic [4:0] count;
    logic       en_in;
    logic       en_out;
    logic [7:0] din;
    logic       ovf_err;
    logic       udf_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int enInCnt = 0;
    int enOutCnt = 0;
    int ovfCnt = 0;
    int udfCnt = 0;
    int bothCnt = 0;
    int lastInCyc = -1;
    int lastOutCyc = -1;
    int lastOvfCyc = -1;
    int lastUdfCyc = -1;

    int baseIn;
    int baseOut;
    int baseOvf;
    int baseUdf;
    int baseBoth;
    int c;

    fifo_btn_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20),
        .DEPTH(16),
        .COUNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_out(btn_out),
        .sw_data(sw_data),
        .count(count),
        .en_in(en_in),
        .en_out(en_out),
        .din(din),
        .ovf_err(ovf_err),
        .udf_err(udf_err)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedge counter used to time strobes
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Pulse monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (en_in) begin
            enInCnt   <= enInCnt + 1;
            lastInCyc <= cyc;
        end
        if (en_out) begin
            enOutCnt   <= enOutCnt + 1;
            lastOutCyc <= cyc;
        end
        if (ovf_err) begin
            ovfCnt     <= ovfCnt + 1;
            lastOvfCyc <= cyc;
        end
        if (udf_err) begin
            udfCnt     <= udfCnt + 1;
            lastUdfCyc <= cyc;
        end
        if (en_in && en_out) begin
            bothCnt <= bothCnt + 1;
        end
    end

    // Advance n posedges, then settle 2 units past the edge
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drive the two raw buttons
    task automatic applyStimulus(input logic pushBtn, input logic popBtn);
        btn_in  = pushBtn;
        btn_out = popBtn;
    endtask

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Snapshot the pulse counters before a test
    task automatic snapshot();
        baseIn   = enInCnt;
        baseOut  = enOutCnt;
        baseOvf  = ovfCnt;
        baseUdf  = udfCnt;
        baseBoth = bothCnt;
    endtask

    initial begin
        rst     = 1'b1;
        btn_in  = 1'b0;
        btn_out = 1'b0;
        sw_data = 8'd0;
        count   = 5'd0;

        // Reset state
        waitCycles(3);
        checkOutput("reset en_in", int'(en_in), 0);
        checkOutput("reset en_out", int'(en_out), 0);
        checkOutput("reset din", int'(din), 0);
        checkOutput("reset ovf_err", int'(ovf_err), 0);
        checkOutput("reset udf_err", int'(udf_err), 0);
        rst = 1'b0;
        waitCycles(2);

        // Test 1: clean press held 20 cycles
        $display("[TB] test 1: clean press");
        count   = 5'd0;
        sw_data = 8'd23;
        snapshot();
        c = cyc;
        applyStimulus(1'b1, 1'b0);
        waitCycles(20);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t1 en_in pulses", enInCnt - baseIn, 1);
        checkOutput("t1 en_in timing", lastInCyc, c + 8);
        checkOutput("t1 din", int'(din), 23);
        checkOutput("t1 ovf pulses", ovfCnt - baseOvf, 0);
        checkOutput("t1 en_out pulses", enOutCnt - baseOut, 0);

        // Test 2: bouncing press then steady level
        $display("[TB] test 2: bounce");
        sw_data = 8'd78;
        snapshot();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            waitCycles(2);
            applyStimulus(1'b0, 1'b0);
            waitCycles(1);
        end
        c = cyc;
        applyStimulus(1'b1, 1'b0);
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t2 en_in pulses", enInCnt - baseIn, 1);
        checkOutput("t2 en_in timing", lastInCyc, c + 8);
        checkOutput("t2 din", int'(din), 78);

        // Test 3a: push into a full FIFO
        $display("[TB] test 3: full / empty rejection");
        count   = 5'd16;
        sw_data = 8'd99;
        snapshot();
        c = cyc;
        applyStimulus(1'b1, 1'b0);
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t3 en_in pulses", enInCnt - baseIn, 0);
        checkOutput("t3 ovf pulses", ovfCnt - baseOvf, 1);
        checkOutput("t3 ovf timing", lastOvfCyc, c + 8);
        checkOutput("t3 din held", int'(din), 78);

        // Test 3b: pop from an empty FIFO
        count = 5'd0;
        snapshot();
        c = cyc;
        applyStimulus(1'b0, 1'b1);
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t3 en_out pulses", enOutCnt - baseOut, 0);
        checkOutput("t3 udf pulses", udfCnt - baseUdf, 1);
        checkOutput("t3 udf timing", lastUdfCyc, c + 8);

        // Test 4: simultaneous push and pop
        $display("[TB] test 4: simultaneous");
        count   = 5'd5;
        sw_data = 8'd66;
        snapshot();
        c = cyc;
        applyStimulus(1'b1, 1'b1);
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t4 en_in pulses", enInCnt - baseIn, 1);
        checkOutput("t4 en_out pulses", enOutCnt - baseOut, 1);
        checkOutput("t4 same cycle", bothCnt - baseBoth, 1);
        checkOutput("t4 en_in timing", lastInCyc, c + 8);
        checkOutput("t4 en_out timing", lastOutCyc, c + 8);
        checkOutput("t4 din", int'(din), 66);
        checkOutput("t4 errors", (ovfCnt - baseOvf) + (udfCnt - baseUdf), 0);

        // Test 5: long hold with a short release glitch, then a real re-press
        $display("[TB] test 5: hold and re-press");
        count = 5'd3;
        snapshot();
        c = cyc;
        applyStimulus(1'b0, 1'b1);
        waitCycles(20);
        applyStimulus(1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1);
        waitCycles(20);
        checkOutput("t5 hold pulses", enOutCnt - baseOut, 1);
        checkOutput("t5 hold timing", lastOutCyc, c + 8);
        applyStimulus(1'b0, 1'b0);
        waitCycles(10);
        c = cyc;
        applyStimulus(1'b0, 1'b1);
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t5 total pulses", enOutCnt - baseOut, 2);
        checkOutput("t5 repress timing", lastOutCyc, c + 8);

        // Test 6: reset in the middle of a press, button kept high
        $display("[TB] test 6: reset mid-press");
        count   = 5'd0;
        sw_data = 8'd45;
        snapshot();
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        rst = 1'b1;
        #1;
        checkOutput("t6 rst en_in", int'(en_in), 0);
        checkOutput("t6 rst din", int'(din), 0);
        checkOutput("t6 rst ovf", int'(ovf_err), 0);
        waitCycles(3);
        checkOutput("t6 no strobe in rst", enInCnt - baseIn, 0);
        rst = 1'b0;
        c = cyc;
        waitCycles(12);
        applyStimulus(1'b0, 1'b0);
        waitCycles(12);
        checkOutput("t6 en_in pulses", enInCnt - baseIn, 1);
        checkOutput("t6 en_in timing", lastInCyc, c + 8);
        checkOutput("t6 din", int'(din), 45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
